// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction handshake, ALU operand/result and writeback report bundle
interface alu_issue_if #(parameter int DW = 4, parameter int SCW = 8);
  logic           in_valid;
  logic           in_ready;
  logic [9:0]     in_instr;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [2:0]     alu_op;
  logic [DW-1:0]  alu_x;
  logic           res_valid;
  logic [1:0]     res_rd;
  logic [DW-1:0]  res_data;
  logic [SCW-1:0] stall_cnt;
  modport master (output in_valid, in_instr, alu_x, input in_ready, alu_a, alu_b, alu_op, res_valid, res_rd, res_data, stall_cnt);
  modport slave (input in_valid, in_instr, alu_x, output in_ready, alu_a, alu_b, alu_op, res_valid, res_rd, res_data, stall_cnt);
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: ID/EX/WB issue control for the ALU; define ALU_ISSUE_FWD_EN to forward EX results instead of stalling
module alu_issue_ctrl #(
  parameter int DW = 4,
  parameter logic [DW-1:0] RST_VAL = '0,
  parameter int SCW = 8
) (
  input logic clk,
  input logic rst_n,
  alu_issue_if.slave bus
);
  logic id_valid, ex_valid, id_advance, hazard_stall;
  logic [9:0] id_instr;
  logic [1:0] ex_rd, rs1, rs2;
  logic [DW-1:0] rf [4];
  logic [DW-1:0] opa, opb, rf_b;
  assign rs1 = id_instr[4:3];
  assign rs2 = id_instr[2:1];
`ifdef ALU_ISSUE_FWD_EN
  assign hazard_stall = 1'b0;
  assign opa = (ex_valid && ex_rd == rs1) ? bus.alu_x : rf[rs1];
  assign rf_b = (ex_valid && ex_rd == rs2) ? bus.alu_x : rf[rs2];
`else
  // rs2 only counts as a source when it is not an immediate
  assign hazard_stall = ex_valid && id_valid && (ex_rd == rs1 || (!id_instr[0] && ex_rd == rs2));
  assign opa = rf[rs1];
  assign rf_b = rf[rs2];
`endif
  assign opb = id_instr[0] ? DW'(rs2) : rf_b;
  assign id_advance = id_valid && !hazard_stall;
  assign bus.in_ready = !id_valid || id_advance;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      ex_valid <= 1'b0;
      ex_rd <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_op <= '0;
      bus.res_valid <= 1'b0;
      bus.res_rd <= '0;
      bus.res_data <= '0;
      bus.stall_cnt <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= RST_VAL;
    end else begin
      if (bus.in_ready) id_valid <= bus.in_valid;
      if (bus.in_ready && bus.in_valid) id_instr <= bus.in_instr;
      ex_valid <= id_advance;
      if (id_advance) begin
        bus.alu_op <= id_instr[9:7];
        bus.alu_a <= opa;
        bus.alu_b <= opb;
        ex_rd <= id_instr[6:5];
      end
      bus.res_valid <= ex_valid;
      if (ex_valid) begin
        rf[ex_rd] <= bus.alu_x;
        bus.res_rd <= ex_rd;
        bus.res_data <= bus.alu_x;
      end
      if (hazard_stall && bus.stall_cnt != '1) bus.stall_cnt <= bus.stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized scoreboard bench against a sequential-execution model
module tb_alu_issue_ctrl;
  logic clk = 0, rst_n = 0;
  int checks = 0, errors = 0, cyc = 0;
  logic [3:0] mrf [4];
  logic [5:0] exp_q [$];
  logic [3:0] log_d [$];
  int log_c [$];
  alu_issue_if #(.DW(4), .SCW(8)) bus ();
  alu_issue_ctrl #(.DW(4), .RST_VAL(4'd0), .SCW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [3:0] alu_f(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    return op == 0 ? a + b : op == 1 ? a - b : op == 2 ? a & b : op == 3 ? a | b : a ^ b;
  endfunction
  assign bus.alu_x = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
  function automatic logic [9:0] mk(int op, int rd, int rs1, int rs2, int imm);
    return {3'(op), 2'(rd), 2'(rs1), 2'(rs2), 1'(imm)};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // program-order execution: results are independent of stalls or forwarding
  task automatic model(input logic [9:0] ins, output logic [3:0] x);
    logic [3:0] a, b;
    a = mrf[ins[4:3]];
    b = ins[0] ? {2'b00, ins[2:1]} : mrf[ins[2:1]];
    x = alu_f(ins[9:7], a, b);
    mrf[ins[6:5]] = x;
    exp_q.push_back({ins[6:5], x});
  endtask
  task automatic send(input logic [9:0] ins, output logic [3:0] x);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1;
    bus.in_instr = ins;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    model(ins, x);
    @(posedge clk);
    #1 bus.in_valid = 0;
    bus.in_instr = 10'($urandom);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk) bus.in_instr = 10'($urandom);
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.res_valid) begin
      if (exp_q.size() == 0) chk("unexpected_result", {bus.res_rd, bus.res_data}, 0);
      else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("res_rd", bus.res_rd, e[5:4]);
        chk("res_data", bus.res_data, e[3:0]);
      end
      log_d.push_back(bus.res_data);
      log_c.push_back(cyc);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    logic [3:0] x, xs [3];
    logic [7:0] s0;
    int n;
    bus.in_valid = 0;
    bus.in_instr = '0;
    for (int i = 0; i < 4; i++) mrf[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_res_valid", bus.res_valid, 0);
      chk("idle_alu_a", bus.alu_a, 0);
      chk("idle_alu_b", bus.alu_b, 0);
      chk("idle_alu_op", bus.alu_op, 0);
      chk("idle_in_ready", bus.in_ready, 1);
      chk("idle_stall_cnt", bus.stall_cnt, 0);
    end
    send(mk(0, 1, 0, 3, 1), x);
    @(posedge clk) #1;
    chk("imm_alu_a", bus.alu_a, 0);
    chk("imm_alu_b", bus.alu_b, 3);
    chk("imm_alu_op", bus.alu_op, 0);
    @(posedge clk) #1;
    chk("imm_res_valid", bus.res_valid, 1);
    chk("imm_res_rd", bus.res_rd, 1);
    chk("imm_res_data", bus.res_data, 3);
    drain();
    send(mk(0, 1, 0, 3, 1), x);
    send(mk(0, 2, 0, 2, 1), x);
    drain();
    s0 = bus.stall_cnt;
    log_d.delete();
    log_c.delete();
    send(mk(0, 3, 1, 2, 0), x);
    send(mk(1, 0, 3, 1, 0), x);
    drain();
    chk("chain_count", log_d.size(), 2);
    if (log_d.size() == 2) begin
      chk("chain_data0", log_d[0], 5);
      chk("chain_data1", log_d[1], 2);
`ifdef ALU_ISSUE_FWD_EN
      chk("chain_gap", log_c[1] - log_c[0], 1);
`else
      chk("chain_gap", log_c[1] - log_c[0], 2);
`endif
    end
`ifdef ALU_ISSUE_FWD_EN
    chk("chain_stalls", bus.stall_cnt - s0, 0);
    chk("fwd_stall_cnt", bus.stall_cnt, 0);
`else
    chk("chain_stalls", bus.stall_cnt - s0, 1);
`endif
    log_d.delete();
    send(mk(0, 1, 2, 1, 1), xs[0]);
    idle(1);
    send(mk(2, 2, 1, 3, 1), xs[1]);
    send(mk(3, 3, 0, 2, 1), xs[2]);
    drain();
    chk("gap_count", log_d.size(), 3);
    for (int i = 0; i < 3 && i < log_d.size(); i++) chk("gap_order", log_d[i], xs[i]);
    for (int i = 0; i < 300; i++) begin
      send(10'($urandom), x);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    send(mk(0, 2, 0, 3, 1), x);
    @(posedge clk) #1 rst_n = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) mrf[i] = 0;
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    idle(3);
    log_d.delete();
    for (int r = 0; r < 4; r++) send(mk(3, r, r, 0, 1), x);
    drain();
    n = log_d.size();
    chk("rst_rf_reads", n, 4);
    for (int i = 0; i < n; i++) chk("rst_rf_val", log_d[i], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
